// File: rtl/usb_flags_i.sv
// usb_flags_i: edge-capturing flag input port with an Avalon-MM slave interface.
// Each in_port bit is synchronized, edge-detected and latched into edgecapture.
// Software reads the data and capture registers, sets the interrupt mask,
// and clears captured bits by writing 1 to them. irq is the OR of the
// masked captures.
module usb_flags_i #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned EDGE_TYPE     = 0,
    parameter logic [31:0] RESET_IRQMASK = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // The arm counter saturates at this value. Edge detection is enabled
    // only when the counter has saturated.
    localparam logic [1:0] ARM_FULL = 2'd3;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [1:0]       arm_q;
    logic [1:0]       arm_d;
    logic             wr_en;

    // A write is a single cycle with chipselect high and write_n low.
    assign wr_en = chipselect & ~write_n;

    // Two-flop synchronizer, plus a copy of the previous synchronized value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Select the edge polarity for this instance.
    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = sync2_q & ~prev_q;
            1:       edge_raw = ~sync2_q & prev_q;
            default: edge_raw = sync2_q ^ prev_q;
        endcase
    end

    // Suppress edges until the pipeline holds real samples. Without this,
    // the static input levels present at reset release would be captured.
    always_comb begin
        arm_d    = (arm_q == ARM_FULL) ? arm_q : arm_q + 2'd1;
        edge_det = (arm_q == ARM_FULL) ? edge_raw : '0;
    end

    // Next state of the mask and capture registers. A new edge wins over a
    // clear of the same bit in the same cycle.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edge_det;
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q     <= '0;
            irqmask_q <= RESET_IRQMASK[WIDTH-1:0];
            edgecap_q <= '0;
        end else begin
            arm_q     <= arm_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Zero-latency read mux. Unused upper bits read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = sync2_q;
            2'd2:    readdata[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata[WIDTH-1:0] = edgecap_q;
            default: readdata = '0;
        endcase
    end

    // The interrupt is driven only from registers, so it is glitch-free.
    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: doc/usb_flags_i.md
USB_FLAGS_I -- requirements
Module: usb_flags_i

Interface
REQ-001 Parameter WIDTH, default 8, number of input flag bits (1..32).
REQ-002 Parameter EDGE_TYPE, default 0, edge that sets a capture bit: 0 rising, 1 falling, 2 either.
REQ-003 Parameter RESET_IRQMASK, default 0, reset value of irqmask[WIDTH-1:0].
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 address  in  2  Avalon-MM slave word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe, valid with chipselect.
REQ-009 writedata  in  32  write data.
REQ-010 in_port  in  WIDTH  asynchronous flag inputs from the USB device.
REQ-011 readdata  out  32  read data, combinational from address, zero-extended.
REQ-012 irq  out  1  active-high level interrupt.

Function
REQ-013 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2); a third register prev SHALL hold the previous sync2.
REQ-014 Register map: address 0 = data (sync2, read-only), 1 = reserved, 2 = irqmask (R/W), 3 = edgecapture (read, write-1-to-clear).
REQ-015 readdata SHALL be {zeros, register[WIDTH-1:0]} for the selected address, 0 for address 1; no read strobe, no read latency, no side effects.
REQ-016 A write is chipselect=1 and write_n=0 in one cycle; registers update on that clock edge.
REQ-017 Writes to address 0 and 1 SHALL be ignored.
REQ-018 Write to address 2 SHALL load irqmask <= writedata[WIDTH-1:0].
REQ-019 Write to address 3 SHALL clear each edgecapture bit i where writedata[i]=1; bits with writedata[i]=0 are unchanged.
REQ-020 Edge for bit i: rising = sync2[i]&~prev[i]; falling = ~sync2[i]&prev[i]; either = sync2[i]^prev[i], per EDGE_TYPE.
REQ-021 A detected edge SHALL set edgecapture[i] to 1 on the next clock edge; the bit stays set until cleared by REQ-019.
REQ-022 Latency: an in_port change stable before clock edge N SHALL be visible at address 0 after edge N+1 and set edgecapture after edge N+2.
REQ-023 Simultaneous edge and write-1-to-clear on the same bit in the same cycle: set SHALL win (bit ends at 1).
REQ-024 A 2-bit arm counter SHALL count 0..3 after reset release and saturate; edge detection SHALL be suppressed while arm<3, so the inputs' static levels at reset release produce no capture.
REQ-025 irq SHALL equal |(edgecapture & irqmask), derived only from registers (glitch-free).
REQ-026 Bits of writedata above WIDTH-1 SHALL be ignored; readdata bits above WIDTH-1 SHALL be 0.
REQ-027 Input pulses shorter than one clock period are not guaranteed to be captured; pulses at least 2 clocks wide SHALL be captured.

Reset
REQ-028 While reset_n=0: sync1, sync2, prev, edgecapture, arm = 0; irqmask = RESET_IRQMASK; irq = 0.
REQ-029 Reset asserted mid-operation SHALL clear all state immediately (asynchronously), including pending captures.
REQ-030 Deassertion needs no special handling beyond REQ-024; the surrounding system provides synchronous release.

Verification
REQ-031 WIDTH=8, EDGE_TYPE=0: hold in_port=8'hFF through reset release -> address 3 reads 0, irq=0 after 10 clocks; address 0 reads 8'hFF.
REQ-032 in_port bit 2 goes 0->1 before edge N -> address 0 bit 2 =1 after N+1, edgecapture=8'h04 after N+2; with irqmask=8'h04, irq=1 from N+2.
REQ-033 edgecapture=8'h05, write 32'h00000001 to address 3 -> edgecapture=8'h04; irq stays 1 while irqmask bit 2 set; write 8'h04 -> edgecapture=0, irq=0.
REQ-034 Rising edge on bit 0 detected in the same cycle as write-1-to-clear of bit 0 -> edgecapture bit 0 =1 afterwards.
REQ-035 EDGE_TYPE=2: 3-clock-wide high pulse on bit 7 sets bit 7; after clear, the falling edge alone sets it again; EDGE_TYPE=1 sets only on the falling edge.
REQ-036 Assert reset_n=0 asynchronously with edgecapture=8'hFF, irqmask=8'hFF -> readdata at address 3 = 0 and irq=0 before the next clock edge; irqmask returns to RESET_IRQMASK.
